filter_rank_entity: RTL and testbench



---
 rtl/filter_rank_pkg.sv | 25 ++
 rtl/filter_rank_cmpswap.sv | 27 ++
 rtl/filter_rank_entity.sv | 126 ++++++++++++
 tb/tb_filter_rank_entity.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_rank_pkg.sv
// ============================================================================
// Module   : filter_rank_pkg
// Purpose  : Shared helpers and the pixel type macro for the rank-order filter.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef FILTER_RANK_PIX_T
`define FILTER_RANK_PIX_T(W) logic [(W)-1:0]
`endif

package filter_rank_pkg;

    // Clocks from the input sample edge to do_o: sort registers plus output register.
    function automatic int rank_latency(input int k, input int s);
        return (k + s - 1) / s + 1;
    endfunction

    function automatic int rank_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/filter_rank_cmpswap.sv
// ============================================================================
// Module   : filter_rank_cmpswap
// Purpose  : Combinational compare-exchange; swaps only when a_i > b_i.
// Revision : 1.0
// ============================================================================
`default_nettype none

module filter_rank_cmpswap
    import filter_rank_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8
) (
    input  `FILTER_RANK_PIX_T(PIXEL_WIDTH) a_i,
    input  `FILTER_RANK_PIX_T(PIXEL_WIDTH) b_i,
    output `FILTER_RANK_PIX_T(PIXEL_WIDTH) lo_o,
    output `FILTER_RANK_PIX_T(PIXEL_WIDTH) hi_o
);

    logic w_swap;

    assign w_swap = (a_i > b_i);
    assign lo_o   = w_swap ? b_i : a_i;
    assign hi_o   = w_swap ? a_i : b_i;

endmodule

`default_nettype wire

// File: rtl/filter_rank_entity.sv
// ============================================================================
// Module   : filter_rank_entity
// Purpose  : Pipelined odd-even transposition rank-order filter with sideband.
// Revision : 1.0
// ============================================================================
`default_nettype none

module filter_rank_entity
    import filter_rank_pkg::*;
#(
    parameter  int KERNEL_SIZE    = 49,
    parameter  int PIXEL_WIDTH    = 8,
    parameter  int STAGES_PER_REG = 1,
    parameter  int USER_WIDTH     = 4,
    localparam int RANK_W         = rank_w(KERNEL_SIZE)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [KERNEL_SIZE*PIXEL_WIDTH-1:0]  xi,
    input  logic [RANK_W-1:0]                   rank_i,
    input  logic                                di_i,
    input  logic [USER_WIDTH-1:0]               user_i,
    output logic [KERNEL_SIZE*PIXEL_WIDTH-1:0]  xo,
    output logic [PIXEL_WIDTH-1:0]              yo,
    output logic                                do_o,
    output logic [USER_WIDTH-1:0]               user_o
);

    typedef logic [KERNEL_SIZE-1:0][PIXEL_WIDTH-1:0] win_t;

    // Index p holds what enters pass p; index KERNEL_SIZE is the sorted result.
    wire win_t                  w_pass_in  [0:KERNEL_SIZE];
    wire win_t                  w_pass_out [0:KERNEL_SIZE-1];
    wire logic                  w_vld      [0:KERNEL_SIZE];
    wire logic [RANK_W-1:0]     w_rank     [0:KERNEL_SIZE];
    wire logic [USER_WIDTH-1:0] w_user     [0:KERNEL_SIZE];

    logic [RANK_W-1:0] w_rank_clamped;

    assign w_rank_clamped = (32'(rank_i) >= 32'(KERNEL_SIZE)) ? RANK_W'(KERNEL_SIZE - 1) : rank_i;

    assign w_pass_in[0] = xi;
    assign w_vld[0]     = di_i;
    assign w_rank[0]    = w_rank_clamped;
    assign w_user[0]    = user_i;

    genvar p, i;
    generate
        for (p = 0; p < KERNEL_SIZE; p++) begin : g_pass
            for (i = 0; i < KERNEL_SIZE; i++) begin : g_elem
                if (((i % 2) == (p % 2)) && (i + 1 < KERNEL_SIZE)) begin : g_cs
                    filter_rank_cmpswap #(
                        .PIXEL_WIDTH (PIXEL_WIDTH)
                    ) u_cs (
                        .a_i  (w_pass_in[p][i]),
                        .b_i  (w_pass_in[p][i+1]),
                        .lo_o (w_pass_out[p][i]),
                        .hi_o (w_pass_out[p][i+1])
                    );
                end else if (!((i >= 1) && (((i - 1) % 2) == (p % 2)))) begin : g_thru
                    // Edge element with no partner in this pass.
                    assign w_pass_out[p][i] = w_pass_in[p][i];
                end
            end

            if ((((p + 1) % STAGES_PER_REG) == 0) || (p == KERNEL_SIZE - 1)) begin : g_reg
                win_t                  data_q;
                logic                  vld_q;
                logic [RANK_W-1:0]     rank_q;
                logic [USER_WIDTH-1:0] user_q;

                // Data and sideband load freely; only the valid bit is reset.
                always_ff @(posedge clk) begin
                    data_q <= w_pass_out[p];
                    rank_q <= w_rank[p];
                    user_q <= w_user[p];
                    if (rst) begin
                        vld_q <= 1'b0;
                    end else begin
                        vld_q <= w_vld[p];
                    end
                end

                assign w_pass_in[p+1] = data_q;
                assign w_vld[p+1]     = vld_q;
                assign w_rank[p+1]    = rank_q;
                assign w_user[p+1]    = user_q;
            end else begin : g_comb
                assign w_pass_in[p+1] = w_pass_out[p];
                assign w_vld[p+1]     = w_vld[p];
                assign w_rank[p+1]    = w_rank[p];
                assign w_user[p+1]    = w_user[p];
            end
        end
    endgenerate

    logic [KERNEL_SIZE*PIXEL_WIDTH-1:0] xo_q;
    logic [PIXEL_WIDTH-1:0]             yo_q;
    logic [PIXEL_WIDTH-1:0]             yo_d;
    logic                               do_q;
    logic [USER_WIDTH-1:0]              user_q;

    assign yo_d = w_pass_in[KERNEL_SIZE][w_rank[KERNEL_SIZE]];

    always_ff @(posedge clk) begin
        if (rst) begin
            xo_q   <= '0;
            yo_q   <= '0;
            do_q   <= 1'b0;
            user_q <= '0;
        end else begin
            xo_q   <= w_pass_in[KERNEL_SIZE];
            yo_q   <= yo_d;
            do_q   <= w_vld[KERNEL_SIZE];
            user_q <= w_user[KERNEL_SIZE];
        end
    end

    assign xo     = xo_q;
    assign yo     = yo_q;
    assign do_o   = do_q;
    assign user_o = user_q;

endmodule

`default_nettype wire

// File: tb/tb_filter_rank_entity.sv
// ============================================================================
// Module   : tb_filter_rank_entity
// Purpose  : Self-checking bench for filter_rank_entity (K=49/S=1 and K=9/S=3).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_filter_rank_entity;
    import filter_rank_pkg::*;

    localparam int K  = 49;
    localparam int W  = 8;
    localparam int U  = 4;
    localparam int RW = 6;
    localparam int L  = rank_latency(49, 1);

    localparam int K2  = 9;
    localparam int W2  = 10;
    localparam int RW2 = 4;
    localparam int L2  = rank_latency(9, 3);

    typedef logic [K*W-1:0] win_t;
    typedef struct { win_t xo; logic [W-1:0] yo; logic [U-1:0] user; int due; } exp_t;
    typedef struct { win_t w; int rank; logic [U-1:0] user; win_t exp_xo; logic [W-1:0] exp_yo; } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic [K*W-1:0] xi = '0;
    logic [RW-1:0]  rank_i = '0;
    logic           di_i = 1'b0;
    logic [U-1:0]   user_i = '0;
    logic [K*W-1:0] xo;
    logic [W-1:0]   yo;
    logic           do_o;
    logic [U-1:0]   user_o;

    logic [K2*W2-1:0] xi2 = '0;
    logic [RW2-1:0]   rank2 = '0;
    logic             di2 = 1'b0;
    logic [U-1:0]     user2 = '0;
    logic [K2*W2-1:0] xo2;
    logic [W2-1:0]    yo2;
    logic             do2;
    logic [U-1:0]     user_o2;

    filter_rank_entity #(
        .KERNEL_SIZE (K), .PIXEL_WIDTH (W), .STAGES_PER_REG (1), .USER_WIDTH (U)
    ) u_dut (
        .clk (clk), .rst (rst), .xi (xi), .rank_i (rank_i), .di_i (di_i), .user_i (user_i),
        .xo (xo), .yo (yo), .do_o (do_o), .user_o (user_o)
    );

    filter_rank_entity #(
        .KERNEL_SIZE (K2), .PIXEL_WIDTH (W2), .STAGES_PER_REG (3), .USER_WIDTH (U)
    ) u_dut9 (
        .clk (clk), .rst (rst), .xi (xi2), .rank_i (rank2), .di_i (di2), .user_i (user2),
        .xo (xo2), .yo (yo2), .do_o (do2), .user_o (user_o2)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_out    = 0;
    bit   chk_en   = 1'b0;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: sort the window as plain integers, then pick the clamped rank.
    function automatic void model(input win_t w, input int r, output win_t xs, output logic [W-1:0] y);
        int a[$];
        for (int k = 0; k < K; k++) a.push_back(int'(w[k*W +: W]));
        a.sort();
        xs = '0;
        for (int k = 0; k < K; k++) xs[k*W +: W] = W'(a[k]);
        y = W'(a[(r >= K) ? K - 1 : r]);
    endfunction

    function automatic win_t rand_win();
        win_t w;
        int   hi;
        hi = ($urandom_range(0, 3) == 0) ? 7 : 255;
        for (int k = 0; k < K; k++) w[k*W +: W] = W'($urandom_range(0, hi));
        return w;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                check("missed window", 0, 1);
                void'(sb.pop_front());
            end
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("do_o valid", 512'(do_o), 1);
                check("xo sorted", 512'(xo), 512'(sb[0].xo));
                check("yo rank", 512'(yo), 512'(sb[0].yo));
                check("user_o", 512'(user_o), 512'(sb[0].user));
                void'(sb.pop_front());
                n_out++;
            end else begin
                check("do_o idle", 512'(do_o), 0);
            end
        end
    end

    task automatic present(input win_t w, input int r, input logic [U-1:0] u,
                           input win_t ex, input logic [W-1:0] ey);
        exp_t e;
        xi = w; rank_i = RW'(r); user_i = u; di_i = 1'b1;
        e.xo = ex; e.yo = ey; e.user = u; e.due = cyc + L;
        sb.push_back(e);
    endtask

    task automatic issue(input win_t w, input int r, input logic [U-1:0] u,
                         input win_t ex, input logic [W-1:0] ey);
        @(posedge clk); #1;
        present(w, r, u, ex, ey);
    endtask

    task automatic issue_rand();
        win_t w, ex;
        logic [W-1:0] ey;
        int r;
        w = rand_win();
        r = $urandom_range(0, 63);
        model(w, r, ex, ey);
        issue(w, r, U'($urandom), ex, ey);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        di_i = 1'b0; xi = rand_win(); rank_i = RW'($urandom); user_i = U'($urandom);
    endtask

    vec_t tbl[6];

    initial begin
        win_t w, ex;
        logic [W-1:0] ey, mx;
        int c0, n0;

        // Directed vectors.
        for (int k = 0; k < K; k++) begin
            tbl[0].w[k*W +: W]      = W'(48 - k);
            tbl[0].exp_xo[k*W +: W] = W'(k);
        end
        tbl[0].rank = 24; tbl[0].user = 4'hA; tbl[0].exp_yo = 8'd24;
        for (int t = 1; t <= 3; t++) begin
            for (int k = 0; k < K; k++) begin
                tbl[t].w[k*W +: W]      = (k == 10) ? 8'h00 : (k == 20) ? 8'hFF : 8'h7F;
                tbl[t].exp_xo[k*W +: W] = (k == 0) ? 8'h00 : (k == K - 1) ? 8'hFF : 8'h7F;
            end
            tbl[t].user = U'(t);
        end
        tbl[1].rank = 0;  tbl[1].exp_yo = 8'h00;
        tbl[2].rank = 24; tbl[2].exp_yo = 8'h7F;
        tbl[3].rank = 48; tbl[3].exp_yo = 8'hFF;
        w = rand_win();
        mx = '0;
        for (int k = 0; k < K; k++) if (w[k*W +: W] > mx) mx = w[k*W +: W];
        model(w, 0, ex, ey);
        tbl[4].w = w; tbl[4].rank = 63; tbl[4].user = 4'h6; tbl[4].exp_xo = ex; tbl[4].exp_yo = mx;
        for (int k = 0; k < K; k++) begin
            tbl[5].w[k*W +: W]      = 8'h33;
            tbl[5].exp_xo[k*W +: W] = 8'h33;
        end
        tbl[5].rank = 5; tbl[5].user = 4'hC; tbl[5].exp_yo = 8'h33;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset do_o", 512'(do_o), 0);
        check("reset xo", 512'(xo), 0);
        check("reset yo", 512'(yo), 0);
        check("reset user_o", 512'(user_o), 0);
        check("reset do_o k9", 512'(do2), 0);
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        // Single window: latency must be exactly L.
        issue(tbl[0].w, tbl[0].rank, tbl[0].user, tbl[0].exp_xo, tbl[0].exp_yo);
        c0 = cyc;
        for (int n = 0; n < 200; n++) begin
            idle();
            @(negedge clk);
            if (do_o === 1'b1) break;
        end
        check("latency", 512'(cyc - c0), 512'(L));
        repeat (10) idle();

        for (int t = 0; t < 6; t++) issue(tbl[t].w, tbl[t].rank, tbl[t].user, tbl[t].exp_xo, tbl[t].exp_yo);
        repeat (L + 5) idle();
        check("table drained", 512'(sb.size()), 0);

        // K=9, S=3 instance: median after 4 clocks.
        begin
            int a[$];
            logic [K2*W2-1:0] exs;
            for (int k = 0; k < K2; k++) xi2[k*W2 +: W2] = W2'($urandom_range(0, 1023));
            for (int k = 0; k < K2; k++) a.push_back(int'(xi2[k*W2 +: W2]));
            a.sort();
            for (int k = 0; k < K2; k++) exs[k*W2 +: W2] = W2'(a[k]);
            @(posedge clk); #1;
            rank2 = 4'd4; user2 = 4'h5; di2 = 1'b1;
            @(negedge clk);
            check("k9 do_o early", 512'(do2), 0);
            @(posedge clk); #1;
            di2 = 1'b0;
            for (int n = 1; n <= L2; n++) begin
                @(negedge clk);
                if (n < L2) begin
                    check("k9 do_o early", 512'(do2), 0);
                end else begin
                    check("k9 do_o", 512'(do2), 1);
                    check("k9 yo median", 512'(yo2), 512'(a[4]));
                    check("k9 xo sorted", 512'(xo2), 512'(exs));
                    check("k9 user_o", 512'(user_o2), 512'(4'h5));
                end
            end
            @(negedge clk);
            check("k9 do_o after", 512'(do2), 0);
        end

        // Random stream with 50% input gaps.
        n0 = n_out;
        for (int n = 0; n < 4096; n++) begin
            while ($urandom_range(0, 1) == 1) idle();
            issue_rand();
        end
        repeat (L + 5) idle();
        check("stream count", 512'(n_out - n0), 4096);
        check("stream drained", 512'(sb.size()), 0);

        // One-cycle reset with 20 windows in flight; the window in the reset cycle is also lost.
        for (int n = 0; n < 20; n++) issue_rand();
        @(posedge clk); #1;
        xi = rand_win(); rank_i = RW'(1); user_i = 4'hF; di_i = 1'b1; rst = 1'b1;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
        n0 = n_out;
        @(posedge clk); #1;
        rst = 1'b0;
        w = rand_win();
        model(w, 7, ex, ey);
        present(w, 7, 4'h3, ex, ey);
        repeat (L + 5) idle();
        check("post-reset count", 512'(n_out - n0), 1);
        check("post-reset drained", 512'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
